// File: rtl/smu_uart_mmio_if.sv
// Data-bus port of the memory-mapped UART: chip select, strobes, address,
// byte enables and the two data paths between the CPU load/store unit and
// the peripheral.
interface smu_uart_mmio_if;
    logic        cs_n;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output cs_n, we, re, addr, wbe, wdata,
        input  rdata
    );

    modport slave (
        input  cs_n, we, re, addr, wbe, wdata,
        output rdata
    );
endinterface

// File: rtl/smu_uart_mmio.sv
// Memory-mapped 8N1 UART: one TX holding register, one RX buffer and a
// status register. The baud rate is an integer division of the system clock.
// CLOCK_FREQ / BAUD_RATE must be at least 4 so the mid-bit sample point exists.
module smu_uart_mmio #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic           clk,
    input  logic           n_rst,
    smu_uart_mmio_if.slave bus,
    output logic           uart_txd,
    input  logic           uart_rxd
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // Bus decode
    logic       sel;
    logic [1:0] reg_idx;
    logic       data_wr;
    logic       stat_wr;
    logic       data_pop;
    logic       unused_bus;

    assign sel        = ~bus.cs_n;
    assign reg_idx    = bus.addr[3:2];
    assign data_wr    = sel & bus.we & bus.wbe[0] & (reg_idx == 2'd0);
    assign stat_wr    = sel & bus.we & bus.wbe[0] & (reg_idx == 2'd1);
    assign data_pop   = sel & bus.re & (reg_idx == 2'd0);
    assign unused_bus = ^{bus.addr[1:0], bus.wdata[31:8], bus.wbe[3:1]};

    // Transmitter state
    uart_state_t      tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;
    logic             tx_busy;

    assign tx_busy = (tx_state != ST_IDLE);

    // TX frame sequencer; the line level is registered from the state held
    // during the previous cycle, so it trails the state by exactly one clock.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (data_wr) begin
                        tx_shift <= bus.wdata[7:0];
                        tx_cnt   <= '0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_state <= ST_STOP;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase

            case (tx_state)
                ST_START: uart_txd <= 1'b0;
                ST_DATA:  uart_txd <= tx_shift[tx_idx];
                default:  uart_txd <= 1'b1;
            endcase
        end
    end

    // Receiver front end
    logic [1:0] rx_sync;
    logic       rx_prev;
    logic       rx_s;
    logic       rx_fall;

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection;
    // everything resets high so a quiet line is not mistaken for a start bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
            rx_prev <= rx_s;
        end
    end

    uart_state_t      rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_done;
    logic             rx_ferr;

    assign rx_done = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST) &&  rx_s;
    assign rx_ferr = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST) && !rx_s;

    // RX frame sequencer: re-check the start bit at its midpoint, then sample
    // every bit one bit-time after the previous sample point.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    // Status and RX buffer; hardware set events take priority over a
    // same-cycle clear from the bus.
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;

    // RX buffer and sticky status flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (data_pop) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && rx_valid && !data_pop) begin
                overrun <= 1'b1;
            end else if (stat_wr && bus.wdata[2]) begin
                overrun <= 1'b0;
            end

            if (rx_ferr) begin
                frame_err <= 1'b1;
            end else if (stat_wr && bus.wdata[3]) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Combinational read mux, forced to zero when the block is not selected
    always_comb begin
        bus.rdata = '0;
        if (sel) begin
            case (reg_idx)
                2'd0:    bus.rdata = {24'h0, rx_byte};
                2'd1:    bus.rdata = {28'h0, frame_err, overrun, rx_valid, tx_busy};
                default: bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_smu_uart_mmio.sv
// Scoreboard bench for smu_uart_mmio: bus stimulus pushes expected read data
// and expected TX bytes into queues, independent monitors pop and compare.
module tb_smu_uart_mmio;

    localparam int CPB = 8;

    logic clk;
    logic n_rst;
    logic uart_txd;
    logic uart_rxd;

    smu_uart_mmio_if bus ();

    smu_uart_mmio #(
        .CLOCK_FREQ (8_000_000),
        .BAUD_RATE  (1_000_000)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bus      (bus),
        .uart_txd (uart_txd),
        .uart_rxd (uart_rxd)
    );

    // 100 MHz-style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to place bus accesses on the reference timeline
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the peripheral's visible state
    int         tx_k = -1000;
    logic [7:0] tx_q[$];
    logic [31:0] exp_q[$];
    string      name_q[$];
    bit         m_valid;
    bit         m_ovr;
    bit         m_ferr;
    logic [7:0] m_byte;
    int         reset_epoch = 0;
    event       rd_ev;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A frame occupies 80 cycles counted from the edge that accepted the write
    function automatic bit model_tx_busy();
        return (cyc >= tx_k) && (cyc < tx_k + 10 * CPB);
    endfunction

    task automatic model_reset();
        tx_k = -1000;
        tx_q.delete();
        m_valid = 0;
        m_ovr   = 0;
        m_ferr  = 0;
        m_byte  = 8'h00;
        reset_epoch++;
    endtask

    // One bus cycle; expected rdata comes from the model before side effects
    task automatic applyStimulus(input bit sel, input bit do_we, input bit do_re,
                                 input logic [3:0] a, input logic [3:0] be,
                                 input logic [31:0] d, input string name);
        logic [31:0] exp;
        bit busy_now;
        @(negedge clk);
        busy_now = model_tx_busy();
        exp = 32'h0;
        if (sel) begin
            case (a[3:2])
                2'd0:    exp = {24'h0, m_byte};
                2'd1:    exp = {28'h0, m_ferr, m_ovr, m_valid, busy_now};
                default: exp = 32'h0;
            endcase
        end
        bus.cs_n  = !sel;
        bus.we    = do_we;
        bus.re    = do_re;
        bus.addr  = a;
        bus.wbe   = be;
        bus.wdata = d;
        exp_q.push_back(exp);
        name_q.push_back(name);
        if (sel && do_we && be[0]) begin
            if (a[3:2] == 2'd0 && !busy_now) begin
                tx_q.push_back(d[7:0]);
                tx_k = cyc + 1;
            end else if (a[3:2] == 2'd1) begin
                if (d[2]) m_ovr = 0;
                if (d[3]) m_ferr = 0;
            end
        end
        if (sel && do_re && a[3:2] == 2'd0) m_valid = 0;
        #2 -> rd_ev;
        @(posedge clk);
        #1;
        bus.cs_n = 1'b1;
        bus.we   = 1'b0;
        bus.re   = 1'b0;
    endtask

    task automatic rd_status(input string name);
        applyStimulus(1, 0, 0, 4'h4, 4'hF, 32'h0, name);
    endtask

    task automatic wr_data(input logic [7:0] b, input string name);
        applyStimulus(1, 1, 0, 4'h0, 4'h1, {24'h0, b}, name);
    endtask

    // Drive one serial frame on uart_rxd, then apply its effect to the model
    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        if (stop) begin
            if (m_valid) m_ovr = 1;
            m_valid = 1;
            m_byte  = b;
        end else begin
            m_ferr = 1;
        end
    endtask

    // Read-data monitor: pops one expectation per bus cycle
    initial begin : rd_monitor
        forever begin
            @(rd_ev);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL rd_underflow: got 0x%0h, expected no access", bus.rdata);
            end else begin
                checkOutput(name_q.pop_front(), bus.rdata, exp_q.pop_front());
            end
        end
    end

    // Serial-line monitor: decodes TX frames at bit centres
    logic [7:0] mon_byte;
    logic       mon_start;
    logic       mon_stop;
    int         mon_epoch;

    initial begin : tx_monitor
        forever begin
            @(negedge uart_txd);
            mon_epoch = reset_epoch;
            repeat (CPB / 2) @(negedge clk);
            mon_start = uart_txd;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_byte[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            mon_stop = uart_txd;
            if (mon_epoch == reset_epoch) begin
                checkOutput("tx_start_bit", {31'h0, mon_start}, 32'h0);
                checkOutput("tx_stop_bit", {31'h0, mon_stop}, 32'h1);
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no frame", mon_byte);
                end else begin
                    checkOutput("tx_byte", {24'h0, mon_byte}, {24'h0, tx_q.pop_front()});
                end
            end
        end
    end

    initial begin : main
        bus.cs_n  = 1'b1;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        bus.addr  = 4'h0;
        bus.wbe   = 4'h0;
        bus.wdata = 32'h0;
        uart_rxd  = 1'b1;
        n_rst     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checkOutput("reset_txd", {31'h0, uart_txd}, 32'h1);
        n_rst = 1'b1;
        rd_status("reset_status");
        applyStimulus(1, 0, 0, 4'h0, 4'hF, 32'h0, "reset_data");

        $display("[TB] scenario 1: transmit 0xA5");
        wr_data(8'hA5, "s1_write");
        for (int i = 0; i < 84; i++) rd_status("s1_busy");

        $display("[TB] scenario 2: write while busy is dropped");
        wr_data(8'h55, "s2_write");
        repeat (10) @(negedge clk);
        wr_data(8'h33, "s2_drop");
        for (int i = 0; i < 75; i++) rd_status("s2_busy");

        $display("[TB] scenario 3: receive 0x3C");
        send_rx(8'h3C, 1'b1);
        rd_status("s3_status");
        applyStimulus(1, 0, 0, 4'h0, 4'hF, 32'h0, "s3_peek");
        rd_status("s3_after_peek");
        applyStimulus(1, 0, 1, 4'h0, 4'hF, 32'h0, "s3_pop");
        rd_status("s3_after_pop");

        $display("[TB] scenario 4: overrun and W1C");
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        applyStimulus(1, 0, 0, 4'h0, 4'hF, 32'h0, "s4_data");
        rd_status("s4_status");
        applyStimulus(1, 1, 0, 4'h4, 4'h1, 32'h4, "s4_w1c");
        rd_status("s4_after_w1c");
        applyStimulus(1, 0, 1, 4'h0, 4'hF, 32'h0, "s4_pop");

        $display("[TB] scenario 5: framing error and glitch");
        send_rx(8'h7E, 1'b0);
        rd_status("s5_ferr");
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (12) @(negedge clk);
        rd_status("s5_after_glitch");
        applyStimulus(1, 0, 0, 4'h0, 4'hF, 32'h0, "s5_data");
        applyStimulus(1, 1, 0, 4'h4, 4'h1, 32'h8, "s5_w1c");
        rd_status("s5_cleared");

        $display("[TB] scenario 6: reset mid-frame");
        wr_data(8'hC3, "s6_write");
        repeat (29) @(negedge clk);
        n_rst = 1'b0;
        model_reset();
        #1;
        checkOutput("s6_txd_in_reset", {31'h0, uart_txd}, 32'h1);
        rd_status("s6_status_in_reset");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (100) @(negedge clk);
        rd_status("s6_status_after");
        wr_data(8'h01, "s6_write_01");
        for (int i = 0; i < 84; i++) rd_status("s6_busy");

        $display("[TB] randomized traffic");
        for (int it = 0; it < 60; it++) begin
            logic [31:0] r;
            r = $urandom;
            case ($urandom_range(0, 5))
                0: applyStimulus(1, 1, r[8], 4'h0, r[3:0] | 4'h1 & {3'b0, r[9] | r[10]},
                                 {16'h0, r[31:24], r[23:16]}, "rnd_wr_data");
                1: rd_status("rnd_status");
                2: applyStimulus(1, 0, r[0], 4'h0, 4'hF, 32'h0, "rnd_rd_data");
                3: applyStimulus(1, 1, 0, 4'h4, r[3:0], r, "rnd_w1c");
                4: send_rx(r[15:8], r[17:16] != 2'b00);
                default: applyStimulus(r[0] | r[1], r[2], r[3], {r[5:4] | 2'b10, r[7:6]},
                                       r[11:8], r, "rnd_misc");
            endcase
        end

        for (int i = 0; i < 2000 && tx_q.size() != 0; i++) @(negedge clk);
        checkOutput("tx_drain", 32'(tx_q.size()), 32'h0);
        repeat (20) @(negedge clk);
        checkOutput("rd_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/smu_uart_mmio.md
# smu_uart_mmio

Memory-mapped UART peripheral on the RV32I core's data bus, sitting directly downstream of the CPU store/load port. It is selected by the address decoder's UART chip select and drives the top-level `UART_TXD` pin and samples `UART_RXD`. It provides one transmit holding register, one receive buffer and a status register. It uses fixed 8N1 framing, with the baud rate derived from the system clock by integer division.

## Interface

Parameters:
- `CLOCK_FREQ`, 125_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bit/s.
- `CLKS_PER_BIT` (localparam) = `CLOCK_FREQ / BAUD_RATE`, truncated, must be ≥ 4.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `cs_n`  in  1  chip select, active low.
- `we`  in  1  write strobe, qualified by `~cs_n`.
- `re`  in  1  read strobe, qualified by `~cs_n`; only this causes read side effects.
- `addr`  in  4  byte address within block; only `addr[3:2]` decoded.
- `wbe`  in  4  byte enables; writes act only when `wbe[0]`=1.
- `wdata`  in  32  write data; only `[7:0]` used.
- `rdata`  out  32  combinational read data, valid in the same cycle as the address.
- `uart_txd`  out  1  serial out, idle high.
- `uart_rxd`  in  1  serial in, asynchronous to `clk`.

Decided: one clock `clk`; reset `n_rst` is asynchronous, active-low.

## Operation

Register map (`addr[3:2]`):
- 0 DATA
  - Write: load TX byte.
  - Read: `{24'b0, rx_byte}`; when `re`, clears `rx_valid`.
- 1 STATUS
  - Read: `{28'b0, frame_err, overrun, rx_valid, tx_busy}`.
  - Write: W1C on bits 3:2 using `wdata[3:2]`.
- 2, 3: read 0, writes ignored.

`rdata` is 0 whenever `cs_n`=1.

TX FSM states: IDLE, START, DATA, STOP.
- IDLE: `uart_txd`=1. A DATA write (with `wbe[0]`) loads the shift register and moves to START.
- A DATA write while `tx_busy`=1 is ignored; the byte is dropped.
- START: `uart_txd`=0 for `CLKS_PER_BIT` cycles.
- DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles; a 3-bit index counts them.
- STOP: `uart_txd`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- `tx_busy` = (state != IDLE).

RX FSM states: IDLE, START, DATA, STOP.
- `uart_rxd` passes through a 2-flop synchronizer, reset value 1.
- IDLE: a synchronized 1→0 transition enters START.
- START: wait `CLKS_PER_BIT/2` cycles, then resample. If 1, it is a glitch: return to IDLE. If 0, go to DATA.
- DATA: sample each bit `CLKS_PER_BIT` cycles after the previous sample, LSB first, 8 bits.
- STOP: sample once `CLKS_PER_BIT` later.
  - Stop=1: write `rx_byte`, set `rx_valid`. If `rx_valid` was already 1, also set `overrun` and overwrite the old byte.
  - Stop=0: discard the byte, set `frame_err`.
  - Either way, return to IDLE.
- The RX FSM does not wait for the line to go high; IDLE re-arms on the next falling edge.

Simultaneous events:
- A DATA read pop in the same cycle as an RX completion leaves `rx_valid`=1 with the new byte and no `overrun`.
- A W1C in the same cycle as a set of the same bit leaves the bit set (set wins).
- `we` and `re` both asserted: both act.

Reset (async, any state):
- `uart_txd`=1; both FSMs go to IDLE.
- `rx_byte`=0; `rx_valid`, `overrun`, `frame_err`, `tx_busy` = 0; counters = 0.
- Reset mid-frame truncates the TX frame. The line goes high immediately.

## Timing

- TX:
  - DATA write sampled at edge k: `tx_busy`=1 after edge k.
  - `uart_txd` falls after edge k+1 (registered output).
  - Frame is 10×`CLKS_PER_BIT` cycles; `tx_busy` falls at the end of the stop bit.
  - A new write is accepted the cycle `tx_busy` reads 0.
- RX: `rx_valid` rises 2 (synchronizer) + 9.5×`CLKS_PER_BIT` (±1) cycles after the `uart_rxd` falling edge.
- Reads: `rdata` is combinational. Read side effects and all writes take effect on the edge where `cs_n`=0.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps; it restarts at 0 at each state entry.

## Test plan

Use `CLOCK_FREQ`=8_000_000 and `BAUD_RATE`=1_000_000 (`CLKS_PER_BIT`=8) for all scenarios.

1. Write 0xA5 to DATA. Expect `uart_txd` low for 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then high for 8. `tx_busy` reads 1 throughout and 0 after 81 cycles.
2. Write 0x55, then write 0x33 while busy. Expect only 0x55 on the line; `tx_busy` clears once.
3. Drive a 0x3C frame on `uart_rxd`. Expect STATUS=0x2 and DATA=0x3C. A DATA read with `re` then gives STATUS=0x0. A read with `re`=0 leaves `rx_valid` unchanged.
4. Send two frames, 0x11 then 0x22, without reading. Expect DATA=0x22 and STATUS=0x6. Write 0x4 to STATUS; expect STATUS=0x2.
5. Send 0x7E with stop bit 0. Expect `rx_valid`=0 and `frame_err`=1. Then drive a 3-cycle low glitch; expect no state change.
6. Assert `n_rst`=0 at cycle 30 of a TX frame. Expect `uart_txd`=1 immediately and STATUS=0. A subsequent write of 0x01 transmits correctly.
